// File: rtl/ps2_keypad_decoder.sv
// ps2_keypad_decoder: turns a PS/2 set-2 scan-code level stream into keypad
// press/release/unknown strobes, a 4-bit key value and a held-key flag.
// Optional: define PS2_EXT_PREFIX_EN to decode the E0-prefixed keypad keys
// (KP Enter -> 14, KP / -> 15). Without it, E0 is reported as an unknown make.
module ps2_keypad_decoder #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic       ck,
    input  logic       reset,
    input  logic [7:0] ps2_key_code,
    output logic       key_press,
    output logic       key_release,
    output logic [3:0] key_value,
    output logic       key_held,
    output logic       key_unknown
);

    localparam logic [7:0]       CODE_IDLE  = 8'h00;
    localparam logic [7:0]       CODE_BREAK = 8'hF0;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef PS2_EXT_PREFIX_EN
    localparam logic [7:0] CODE_EXT = 8'hE0;
    typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} state_t;
`else
    typedef enum logic [0:0] {IDLE, BREAK} state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       prev_code;
    logic             accept;
    logic [4:0]       kp;
    logic             press_d, release_d, unknown_d, held_d;
    logic [3:0]       value_d;

    // Set-2 keypad table: {hit, value}; hit=0 means the code is not a keypad key.
    function automatic logic [4:0] keypad_map(input logic [7:0] code);
        case (code)
            8'h70:   keypad_map = {1'b1, 4'd0};
            8'h69:   keypad_map = {1'b1, 4'd1};
            8'h72:   keypad_map = {1'b1, 4'd2};
            8'h7A:   keypad_map = {1'b1, 4'd3};
            8'h6B:   keypad_map = {1'b1, 4'd4};
            8'h73:   keypad_map = {1'b1, 4'd5};
            8'h74:   keypad_map = {1'b1, 4'd6};
            8'h6C:   keypad_map = {1'b1, 4'd7};
            8'h75:   keypad_map = {1'b1, 4'd8};
            8'h7D:   keypad_map = {1'b1, 4'd9};
            8'h79:   keypad_map = {1'b1, 4'd10};
            8'h7B:   keypad_map = {1'b1, 4'd11};
            8'h7C:   keypad_map = {1'b1, 4'd12};
            8'h71:   keypad_map = {1'b1, 4'd13};
            default: keypad_map = 5'd0;
        endcase
    endfunction

`ifdef PS2_EXT_PREFIX_EN
    // E0-prefixed keypad keys: {hit, value}.
    function automatic logic [4:0] ext_map(input logic [7:0] code);
        case (code)
            8'h5A:   ext_map = {1'b1, 4'd14};
            8'h4A:   ext_map = {1'b1, 4'd15};
            default: ext_map = 5'd0;
        endcase
    endfunction
`endif

    // A byte counts once: it must differ from last cycle's level and not be idle.
    assign accept = (ps2_key_code != prev_code) && (ps2_key_code != CODE_IDLE);
    assign kp     = keypad_map(ps2_key_code);

    // Register the FSM, timeout counter, previous code and decoded outputs.
    always_ff @(posedge ck) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            prev_code   <= CODE_IDLE;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_unknown <= 1'b0;
            key_value   <= 4'd0;
            key_held    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prev_code   <= ps2_key_code;
            key_press   <= press_d;
            key_release <= release_d;
            key_unknown <= unknown_d;
            key_value   <= value_d;
            key_held    <= held_d;
        end
    end

    // Next-state, timeout and strobe decode for the accepted byte.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        press_d   = 1'b0;
        release_d = 1'b0;
        unknown_d = 1'b0;
        value_d   = key_value;
        held_d    = key_held;

        // A prefix state with no new byte ages toward abort; a new byte restarts it.
        if (state_q != IDLE && !accept) begin
            if (cnt_q == CNT_LAST) begin
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (ps2_key_code == CODE_BREAK) begin
                        state_d = BREAK;
`ifdef PS2_EXT_PREFIX_EN
                    end else if (ps2_key_code == CODE_EXT) begin
                        state_d = EXT;
`endif
                    end else if (kp[4]) begin
                        press_d = 1'b1;
                        value_d = kp[3:0];
                        held_d  = 1'b1;
                    end else begin
                        unknown_d = 1'b1;
                    end
                end
                BREAK: begin
                    if (ps2_key_code != CODE_BREAK) begin
                        state_d = IDLE;
                        if (kp[4]) begin
                            release_d = 1'b1;
                            value_d   = kp[3:0];
                            if (kp[3:0] == key_value) held_d = 1'b0;
                        end
                    end
                end
`ifdef PS2_EXT_PREFIX_EN
                EXT: begin
                    state_d = IDLE;
                    if (ps2_key_code == CODE_BREAK) begin
                        state_d = EXT_BREAK;
                    end else if (ext_map(ps2_key_code) != 5'd0) begin
                        press_d = 1'b1;
                        value_d = ext_map(ps2_key_code) & 5'h0F;
                        held_d  = 1'b1;
                    end
                end
                EXT_BREAK: begin
                    state_d = IDLE;
                    if (ext_map(ps2_key_code) != 5'd0) begin
                        release_d = 1'b1;
                        value_d   = ext_map(ps2_key_code) & 5'h0F;
                        if ((ext_map(ps2_key_code) & 5'h0F) == {1'b0, key_value}) held_d = 1'b0;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_keypad_decoder.sv
// Self-checking bench for ps2_keypad_decoder: a behavioural model predicts
// events into a scoreboard queue; a negedge monitor pops and compares them.
// Honours PS2_EXT_PREFIX_EN the same way as the design.
module tb_ps2_keypad_decoder;

    localparam int TO = 16;
`ifdef PS2_EXT_PREFIX_EN
    localparam bit EXT_EN = 1'b1;
`else
    localparam bit EXT_EN = 1'b0;
`endif

    logic       ck = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] ps2_key_code = 8'h00;
    logic       key_press, key_release, key_held, key_unknown;
    logic [3:0] key_value;

    ps2_keypad_decoder #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .ck          (ck),
        .reset       (reset),
        .ps2_key_code(ps2_key_code),
        .key_press   (key_press),
        .key_release (key_release),
        .key_value   (key_value),
        .key_held    (key_held),
        .key_unknown (key_unknown)
    );

    always #5 ck = ~ck;

    typedef struct {
        int kind;   // 1 press, 2 release, 3 unknown
        int value;
        int held;
    } evt_t;

    evt_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // model state
    int         m_state = 0;  // 0 idle, 1 break, 2 ext, 3 ext_break
    logic [7:0] m_prev  = 8'h00;
    int         m_cnt   = 0;
    int         m_value = 0;
    int         m_held  = 0;
    int         exp_value = 0;
    int         exp_held  = 0;
    bit         mon_en    = 1'b0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int map_code(input logic [7:0] c);
        case (c)
            8'h70: return 0;  8'h69: return 1;  8'h72: return 2;  8'h7A: return 3;
            8'h6B: return 4;  8'h73: return 5;  8'h74: return 6;  8'h6C: return 7;
            8'h75: return 8;  8'h7D: return 9;  8'h79: return 10; 8'h7B: return 11;
            8'h7C: return 12; 8'h71: return 13;
            default: return -1;
        endcase
    endfunction

    task automatic push_press(input int v);
        evt_t e;
        m_value = v;
        m_held  = 1;
        e = '{1, v, 1};
        sb.push_back(e);
    endtask

    task automatic push_release(input int v);
        evt_t e;
        if (v == m_value) m_held = 0;
        m_value = v;
        e = '{2, v, m_held};
        sb.push_back(e);
    endtask

    task automatic push_unknown();
        evt_t e;
        e = '{3, m_value, m_held};
        sb.push_back(e);
    endtask

    task automatic model_step(input logic [7:0] c);
        bit acc;
        int v;
        acc    = (c != m_prev) && (c != 8'h00);
        m_prev = c;
        if (!acc) begin
            if (m_state != 0) begin
                m_cnt++;
                if (m_cnt >= TO) begin
                    m_state = 0;
                    m_cnt   = 0;
                end
            end
        end else begin
            m_cnt = 0;
            v = map_code(c);
            case (m_state)
                0: begin
                    if (c == 8'hF0) m_state = 1;
                    else if (EXT_EN && c == 8'hE0) m_state = 2;
                    else if (v >= 0) push_press(v);
                    else push_unknown();
                end
                1: begin
                    if (c != 8'hF0) begin
                        if (v >= 0) push_release(v);
                        m_state = 0;
                    end
                end
                2: begin
                    m_state = 0;
                    if (c == 8'h5A) push_press(14);
                    else if (c == 8'h4A) push_press(15);
                    else if (c == 8'hF0) m_state = 3;
                end
                default: begin
                    m_state = 0;
                    if (c == 8'h5A) push_release(14);
                    else if (c == 8'h4A) push_release(15);
                end
            endcase
        end
    endtask

    task automatic drive(input logic [7:0] c);
        ps2_key_code = c;
        model_step(c);
        @(posedge ck);
        #1;
        exp_value = m_value;
        exp_held  = m_held;
    endtask

    task automatic drive_n(input logic [7:0] c, input int n);
        for (int i = 0; i < n; i++) drive(c);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        ps2_key_code = 8'h00;
        @(posedge ck);
        #1;
        reset     = 1'b0;
        m_state   = 0;
        m_prev    = 8'h00;
        m_cnt     = 0;
        m_value   = 0;
        m_held    = 0;
        exp_value = 0;
        exp_held  = 0;
    endtask

    // Monitor: compare every strobe against the scoreboard, track value/held each cycle.
    always @(negedge ck) begin
        if (mon_en && !reset) begin
            int   nstb;
            int   kind;
            evt_t e;
            nstb = int'(key_press) + int'(key_release) + int'(key_unknown);
            if (nstb != 0) begin
                check_eq("strobe_onehot", nstb, 1);
                kind = key_press ? 1 : (key_release ? 2 : 3);
                check_eq("sb_nonempty", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_eq("evt_kind", kind, e.kind);
                    check_eq("evt_value", int'(key_value), e.value);
                    check_eq("evt_held", int'(key_held), e.held);
                end
            end
            check_eq("key_value", int'(key_value), exp_value);
            check_eq("key_held", int'(key_held), exp_held);
        end
    end

    logic [7:0] pool [12] = '{8'h00, 8'h69, 8'h72, 8'hF0, 8'hE0, 8'h5A,
                              8'h4A, 8'h1C, 8'h70, 8'h7D, 8'h79, 8'h71};

    initial begin
        // reset state
        repeat (2) @(posedge ck);
        #1;
        check_eq("rst_press", int'(key_press), 0);
        check_eq("rst_release", int'(key_release), 0);
        check_eq("rst_unknown", int'(key_unknown), 0);
        check_eq("rst_value", int'(key_value), 0);
        check_eq("rst_held", int'(key_held), 0);
        do_reset();
        mon_en = 1'b1;

        // repeated bytes and break prefix
        drive_n(8'h69, 3); drive_n(8'hF0, 3); drive_n(8'h69, 3); drive(8'h00);
        drive_n(8'h00, 2);

        // same key twice with idle between
        drive_n(8'h6B, 5); drive(8'h00); drive_n(8'h6B, 5); drive_n(8'h00, 2);

        // timeout abort, then a fresh make
        drive(8'hF0); drive_n(8'h00, TO + 2); drive(8'h72); drive_n(8'h00, 2);

        // timeout boundary: one cycle short still releases, exact limit aborts
        drive(8'hF0); drive_n(8'h00, TO - 1); drive(8'h72); drive(8'h00);
        drive(8'h69); drive(8'hF0); drive_n(8'h00, TO); drive(8'h69); drive(8'h00);

        // release of a non-held key keeps key_held
        drive(8'h69); drive(8'h72); drive(8'hF0); drive(8'h69); drive_n(8'h00, 2);

        // unknown make, then reset while in BREAK
        drive(8'h1C); drive(8'h00);
        drive(8'hF0);
        do_reset();
        drive(8'h7D); drive_n(8'h00, 2);

        // every keypad code press/release
        for (int i = 0; i < 256; i++) begin
            if (map_code(8'(i)) >= 0) begin
                drive(8'(i)); drive(8'hF0); drive(8'(i)); drive(8'h00);
            end
        end

        // extended prefix sequence (unknown pulses when the feature is off)
        drive(8'hE0); drive(8'h5A); drive(8'hE0); drive(8'hF0); drive(8'h5A); drive_n(8'h00, 2);
        drive(8'hE0); drive(8'h4A); drive(8'hE0); drive(8'h1C); drive_n(8'h00, 2);

        // random stream
        for (int i = 0; i < 600; i++) drive(pool[$urandom_range(0, 11)]);

        drive_n(8'h00, TO + 4);
        check_eq("sb_drain", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
